// File: rtl/accum_feeder.sv
// accum_feeder: sequences one configured tile of dot-product results into tagged accumulator beats,
// then waits for the accumulator's batch-done pulse before taking the next tile.
module accum_feeder #(
  parameter int DATAW      = 32,
  parameter int DEPTH      = 512,
  parameter int ADDRW      = $clog2(DEPTH),
  parameter int FIFO_DEPTH = 128,
  parameter int TIMEOUT    = 1024
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [ADDRW-1:0] cfg_base_addr,
  input  logic [7:0]       cfg_num_rows,
  input  logic [7:0]       cfg_num_passes,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [DATAW-1:0] s_data,
  output logic             acc_valid,
  output logic [DATAW-1:0] acc_data,
  output logic [ADDRW-1:0] acc_addr,
  output logic             acc_accum,
  output logic             acc_last,
  output logic [7:0]       acc_num_valids,
  input  logic             acc_done,
  output logic             busy,
  output logic             tile_done,
  output logic             err_cfg,
  output logic             err_timeout,
  output logic             err_proto
);
  localparam int TW = $clog2(TIMEOUT) + 1;
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_DONE} state_t;
  state_t state_q, state_d;
  logic [ADDRW-1:0] base_q, base_d, acc_addr_q, acc_addr_d;
  logic [7:0] rows_q, rows_d, n_q, n_d, k_q, k_d, row_q, row_d, pass_q, pass_d, num_q, num_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic [DATAW-1:0] acc_data_q, acc_data_d;
  logic acc_valid_q, acc_valid_d, acc_accum_q, acc_accum_d, acc_last_q, acc_last_d;
  logic tile_done_q, tile_done_d, err_cfg_q, err_cfg_d, err_timeout_q, err_timeout_d, err_proto_q, err_proto_d;
  logic [15:0] prod;
  logic [ADDRW:0] addr_sum;
  logic hs, cfg_ok, last;
  always_comb begin
    prod = {8'd0, cfg_num_rows} * {8'd0, cfg_num_passes};
    cfg_ok = prod != 16'd0 && prod <= 16'(FIFO_DEPTH);
    hs = s_valid && state_q == ISSUE;
    addr_sum = {1'b0, base_q} + (ADDRW+1)'(row_q);
    last = k_q == n_q - 8'd1;
    state_d = state_q;
    base_d = base_q;
    rows_d = rows_q;
    n_d = n_q;
    k_d = k_q;
    row_d = row_q;
    pass_d = pass_q;
    num_d = num_q;
    tmo_d = tmo_q;
    acc_valid_d = hs;
    acc_data_d = acc_data_q;
    acc_addr_d = acc_addr_q;
    acc_accum_d = acc_accum_q;
    acc_last_d = acc_last_q;
    tile_done_d = 1'b0;
    err_cfg_d = err_cfg_q;
    err_timeout_d = err_timeout_q;
    err_proto_d = err_proto_q | (acc_done && state_q != WAIT_DONE);
    case (state_q)
      IDLE: if (cfg_valid) begin
        if (cfg_ok) begin
          base_d = cfg_base_addr;
          rows_d = cfg_num_rows;
          n_d = prod[7:0];
          num_d = prod[7:0];
          k_d = 8'd0;
          row_d = 8'd0;
          pass_d = 8'd0;
          state_d = ISSUE;
        end else err_cfg_d = 1'b1;
      end
      ISSUE: begin
        tmo_d = '0;
        if (hs) begin
          acc_data_d = s_data;
          acc_addr_d = addr_sum >= (ADDRW+1)'(DEPTH) ? ADDRW'(addr_sum - (ADDRW+1)'(DEPTH)) : addr_sum[ADDRW-1:0];
          acc_accum_d = pass_q != 8'd0;
          acc_last_d = last;
          k_d = k_q + 8'd1;
          row_d = row_q == rows_q - 8'd1 ? 8'd0 : row_q + 8'd1;
          pass_d = row_q == rows_q - 8'd1 ? pass_q + 8'd1 : pass_q;
          state_d = last ? WAIT_DONE : ISSUE;
        end
      end
      WAIT_DONE: begin
        tmo_d = tmo_q + 1'b1;
        if (acc_done) begin
          tile_done_d = 1'b1;
          state_d = IDLE;
        end else if (tmo_q == TW'(TIMEOUT - 1)) begin
          err_timeout_d = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      base_q <= '0;
      rows_q <= '0;
      n_q <= '0;
      k_q <= '0;
      row_q <= '0;
      pass_q <= '0;
      num_q <= '0;
      tmo_q <= '0;
      acc_valid_q <= 1'b0;
      acc_data_q <= '0;
      acc_addr_q <= '0;
      acc_accum_q <= 1'b0;
      acc_last_q <= 1'b0;
      tile_done_q <= 1'b0;
      err_cfg_q <= 1'b0;
      err_timeout_q <= 1'b0;
      err_proto_q <= 1'b0;
    end else begin
      state_q <= state_d;
      base_q <= base_d;
      rows_q <= rows_d;
      n_q <= n_d;
      k_q <= k_d;
      row_q <= row_d;
      pass_q <= pass_d;
      num_q <= num_d;
      tmo_q <= tmo_d;
      acc_valid_q <= acc_valid_d;
      acc_data_q <= acc_data_d;
      acc_addr_q <= acc_addr_d;
      acc_accum_q <= acc_accum_d;
      acc_last_q <= acc_last_d;
      tile_done_q <= tile_done_d;
      err_cfg_q <= err_cfg_d;
      err_timeout_q <= err_timeout_d;
      err_proto_q <= err_proto_d;
    end
  end
  assign cfg_ready = state_q == IDLE;
  assign s_ready = state_q == ISSUE;
  assign busy = state_q != IDLE;
  assign acc_valid = acc_valid_q;
  assign acc_data = acc_data_q;
  assign acc_addr = acc_addr_q;
  assign acc_accum = acc_accum_q;
  assign acc_last = acc_last_q;
  assign acc_num_valids = num_q;
  assign tile_done = tile_done_q;
  assign err_cfg = err_cfg_q;
  assign err_timeout = err_timeout_q;
  assign err_proto = err_proto_q;
endmodule

// File: tb/tb_accum_feeder.sv
// tb_accum_feeder: directed tiles with a beat scoreboard checked by an independent monitor.
module tb_accum_feeder;
  logic clk = 0, rst = 1;
  logic cfg_valid = 0, cfg_ready;
  logic [8:0] cfg_base_addr = 0;
  logic [7:0] cfg_num_rows = 0, cfg_num_passes = 0;
  logic s_valid = 0, s_ready;
  logic [31:0] s_data = 0;
  logic acc_valid, acc_accum, acc_last, acc_done = 0;
  logic [31:0] acc_data;
  logic [8:0] acc_addr;
  logic [7:0] acc_num_valids;
  logic busy, tile_done, err_cfg, err_timeout, err_proto;
  int checks = 0, errors = 0;
  typedef struct packed {logic [31:0] d; logic [8:0] a; logic ac; logic l;} beat_t;
  beat_t q[$];

  accum_feeder dut (.clk(clk), .rst(rst), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_base_addr(cfg_base_addr), .cfg_num_rows(cfg_num_rows), .cfg_num_passes(cfg_num_passes),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .acc_valid(acc_valid), .acc_data(acc_data),
    .acc_addr(acc_addr), .acc_accum(acc_accum), .acc_last(acc_last), .acc_num_valids(acc_num_valids),
    .acc_done(acc_done), .busy(busy), .tile_done(tile_done), .err_cfg(err_cfg),
    .err_timeout(err_timeout), .err_proto(err_proto));

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && acc_valid) begin
      beat_t b, e;
      b = '{d: acc_data, a: acc_addr, ac: acc_accum, l: acc_last};
      if (q.size() == 0) chk("unexpected_beat", {b.d[19:0], b.a, b.ac, b.l}, 32'hffffffff);
      else begin
        e = q.pop_front();
        chk("beat_data", b.d, e.d);
        chk("beat_addr", 32'(b.a), 32'(e.a));
        chk("beat_accum", 32'(b.ac), 32'(e.ac));
        chk("beat_last", 32'(b.l), 32'(e.l));
      end
    end
  end

  task automatic cfg(input int base, input int r, input int p);
    int n = 0;
    cfg_valid = 1; cfg_base_addr = 9'(base); cfg_num_rows = 8'(r); cfg_num_passes = 8'(p);
    while (!cfg_ready && n < 2000) begin @(negedge clk); n++; end
    chk("cfg_wait", 32'(cfg_ready), 1);
    @(negedge clk);
    cfg_valid = 0;
  endtask

  task automatic send(input int d, input int a, input bit ac, input bit l, input int gap);
    int n = 0;
    q.push_back('{d: 32'(d), a: 9'(a), ac: ac, l: l});
    s_valid = 1; s_data = 32'(d);
    while (!s_ready && n < 100) begin @(negedge clk); n++; end
    chk("s_ready_wait", 32'(s_ready), 1);
    @(negedge clk);
    s_valid = 0;
    repeat (gap) @(negedge clk);
  endtask

  task automatic tile(input int base, input int r, input int p, input int d0, input int gap);
    cfg(base, r, p);
    chk("num_valids", 32'(acc_num_valids), 32'(r * p));
    for (int pp = 0; pp < p; pp++)
      for (int rr = 0; rr < r; rr++)
        send(d0 + pp * r + rr, (base + rr) % 512, pp != 0, pp == p - 1 && rr == r - 1, gap);
  endtask

  task automatic finish_tile();
    chk("wait_s_ready", 32'(s_ready), 0);
    chk("wait_busy", 32'(busy), 1);
    acc_done = 1;
    @(negedge clk);
    acc_done = 0;
    chk("tile_done", 32'(tile_done), 1);
    chk("cfg_ready_after", 32'(cfg_ready), 1);
    @(negedge clk);
    chk("tile_done_pulse", 32'(tile_done), 0);
    chk("queue_empty", 32'(q.size()), 0);
  endtask

  initial begin
    int n;
    bit saw_done;
    repeat (2) @(negedge clk);
    chk("rst_cfg_ready", 32'(cfg_ready), 1);
    chk("rst_s_ready", 32'(s_ready), 0);
    chk("rst_acc_valid", 32'(acc_valid), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_num", 32'(acc_num_valids), 0);
    rst = 0;
    @(negedge clk);
    tile(10, 4, 1, 1, 0);
    finish_tile();
    tile(0, 2, 3, 100, 0);
    finish_tile();
    tile(510, 4, 1, 200, 0);
    finish_tile();
    cfg(0, 0, 5);
    chk("err_cfg_r0", 32'(err_cfg), 1);
    chk("err_cfg_idle", 32'(busy), 0);
    cfg(0, 16, 16);
    chk("err_cfg_256", 32'(err_cfg), 1);
    chk("err_cfg_idle2", 32'(busy), 0);
    chk("err_cfg_nobeats", 32'(q.size()), 0);
    chk("no_timeout_yet", 32'(err_timeout), 0);
    tile(7, 1, 1, 300, 0);
    n = 0; saw_done = 0;
    while (busy && n < 2000) begin
      @(negedge clk);
      n++;
      if (tile_done) saw_done = 1;
    end
    chk("timeout_cycles", 32'(n), 1024);
    chk("err_timeout", 32'(err_timeout), 1);
    chk("timeout_no_done", 32'(saw_done), 0);
    chk("no_proto_yet", 32'(err_proto), 0);
    cfg(40, 2, 1);
    send(400, 40, 0, 0, 0);
    acc_done = 1;
    @(negedge clk);
    acc_done = 0;
    chk("err_proto", 32'(err_proto), 1);
    chk("proto_still_busy", 32'(busy), 1);
    send(401, 41, 0, 1, 0);
    finish_tile();
    cfg(20, 3, 2);
    for (int i = 0; i < 3; i++) send(500 + i, 20 + i, 0, 0, 2);
    s_valid = 1; s_data = 32'd999;
    rst = 1;
    repeat (2) @(negedge clk);
    rst = 0; s_valid = 0;
    @(negedge clk);
    chk("post_rst_acc_valid", 32'(acc_valid), 0);
    chk("post_rst_acc_data", acc_data, 0);
    chk("post_rst_acc_addr", 32'(acc_addr), 0);
    chk("post_rst_flags", {27'd0, acc_accum, acc_last, tile_done, busy, s_ready}, 0);
    chk("post_rst_errs", {29'd0, err_cfg, err_timeout, err_proto}, 0);
    chk("post_rst_num", 32'(acc_num_valids), 0);
    chk("post_rst_cfg_ready", 32'(cfg_ready), 1);
    chk("post_rst_queue", 32'(q.size()), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
